trap_ctrl: RTL and testbench

- Trap/return sequencer sitting between the commit stage and the machine-mode CSR file.
- Samples committing instructions for ecall, ebreak, mret and pending timer interrupts, then prioritises them.
- Sequences each event: pipeline flush handshake, then a one-cycle CSR update pulse (trap_en/ret_en), then a PC redirect handshake to fetch.

---
 rtl/trap_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_trap_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// trap_ctrl: trap/return sequencer between commit and the machine-mode CSR file.
//
// It samples a committing instruction in IDLE for a timer interrupt, ecall,
// ebreak or mret, with priority irq > ecall > ebreak > mret. It then runs
// the event through four states: IDLE -> FLUSH -> COMMIT -> REDIRECT -> IDLE.
//   FLUSH    : flush_req is high until flush_ack, or until the timeout fires.
//   COMMIT   : one-cycle trap_en / ret_en pulse to the CSR file.
//   REDIRECT : redirect_valid/redirect_pc are held until redirect_ready.
//
// Ports
//   clk, rst (async, active low)
//   inst_valid/inst_addr/inst_ecall/inst_ebreak/inst_mret : commit-stage event
//   clint_mtip, mstatus_mie, mie_mtie                     : interrupt qualifiers
//   mtvec, mepc                                           : CSR values
//   flush_ack, redirect_ready                             : handshakes in
//   pipe_stall (comb), flush_req, trap_en, ret_en, trap_cause, trap_epc,
//   redirect_valid, redirect_pc, flush_timeout (sticky)   : registered outputs
module trap_ctrl #(
    parameter int ADDR_W   = 64,
    parameter int DATA_W   = 64,
    parameter int FLUSH_TO = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_valid,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic              inst_ecall,
    input  logic              inst_ebreak,
    input  logic              inst_mret,
    input  logic              clint_mtip,
    input  logic              mstatus_mie,
    input  logic              mie_mtie,
    input  logic [ADDR_W-1:0] mtvec,
    input  logic [ADDR_W-1:0] mepc,
    input  logic              flush_ack,
    input  logic              redirect_ready,
    output logic              pipe_stall,
    output logic              flush_req,
    output logic              trap_en,
    output logic              ret_en,
    output logic [DATA_W-1:0] trap_cause,
    output logic [ADDR_W-1:0] trap_epc,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              flush_timeout
);

    typedef enum logic [1:0] {IDLE, FLUSH, COMMIT, REDIRECT} state_e;

    localparam logic [15:0] TO_LAST = 16'(FLUSH_TO - 1);

    state_e            state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0] cause_q, cause_d;
    logic [ADDR_W-1:0] epc_q, epc_d;
    logic [ADDR_W-1:0] target_q, target_d;
    logic              is_ret_q, is_ret_d;
    logic              is_irq_q, is_irq_d;
    logic              flush_req_q, flush_req_d;
    logic              trap_en_q, trap_en_d;
    logic              ret_en_q, ret_en_d;
    logic              redirect_valid_q, redirect_valid_d;
    logic              flush_timeout_q, flush_timeout_d;

    logic              irq;
    logic [ADDR_W-1:0] vec_base;

    assign irq      = clint_mtip & mstatus_mie & mie_mtie;
    assign vec_base = {mtvec[ADDR_W-1:2], 2'b00};

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        cause_d         = cause_q;
        epc_d           = epc_q;
        target_d        = target_q;
        is_ret_d        = is_ret_q;
        is_irq_d        = is_irq_q;
        flush_timeout_d = flush_timeout_q;

        case (state_q)
            IDLE: begin
                if (inst_valid && (irq || inst_ecall || inst_ebreak || inst_mret)) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                    if (irq) begin
                        // Interrupt squashes the instruction; it re-executes after mret.
                        cause_d  = {1'b1, (DATA_W-1)'(7)};
                        epc_d    = inst_addr;
                        is_ret_d = 1'b0;
                        is_irq_d = 1'b1;
                    end else if (inst_ecall) begin
                        cause_d  = DATA_W'(11);
                        epc_d    = inst_addr;
                        is_ret_d = 1'b0;
                        is_irq_d = 1'b0;
                    end else if (inst_ebreak) begin
                        cause_d  = DATA_W'(3);
                        epc_d    = inst_addr;
                        is_ret_d = 1'b0;
                        is_irq_d = 1'b0;
                    end else begin
                        // mret leaves cause/epc showing the last trap.
                        is_ret_d = 1'b1;
                        is_irq_d = 1'b0;
                    end
                end
            end
            FLUSH: begin
                cnt_d = cnt_q + 16'd1;
                if (flush_ack) begin
                    state_d = COMMIT;
                end else if (cnt_q == TO_LAST) begin
                    state_d         = COMMIT;
                    flush_timeout_d = 1'b1;
                end
            end
            COMMIT: begin
                state_d = REDIRECT;
                if (is_ret_q)
                    target_d = mepc;
                else if (is_irq_q && mtvec[1:0] == 2'b01)
                    target_d = vec_base + ADDR_W'(28);   // vectored: base + 4*cause
                else
                    target_d = vec_base;
            end
            REDIRECT: begin
                if (redirect_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered, so they are derived from the next state.
        flush_req_d      = (state_d == FLUSH);
        trap_en_d        = (state_d == COMMIT) && !is_ret_d;
        ret_en_d         = (state_d == COMMIT) &&  is_ret_d;
        redirect_valid_d = (state_d == REDIRECT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            cause_q          <= '0;
            epc_q            <= '0;
            target_q         <= '0;
            is_ret_q         <= 1'b0;
            is_irq_q         <= 1'b0;
            flush_req_q      <= 1'b0;
            trap_en_q        <= 1'b0;
            ret_en_q         <= 1'b0;
            redirect_valid_q <= 1'b0;
            flush_timeout_q  <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            cause_q          <= cause_d;
            epc_q            <= epc_d;
            target_q         <= target_d;
            is_ret_q         <= is_ret_d;
            is_irq_q         <= is_irq_d;
            flush_req_q      <= flush_req_d;
            trap_en_q        <= trap_en_d;
            ret_en_q         <= ret_en_d;
            redirect_valid_q <= redirect_valid_d;
            flush_timeout_q  <= flush_timeout_d;
        end
    end

    assign pipe_stall     = (state_q != IDLE);
    assign flush_req      = flush_req_q;
    assign trap_en        = trap_en_q;
    assign ret_en         = ret_en_q;
    assign trap_cause     = cause_q;
    assign trap_epc       = epc_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = target_q;
    assign flush_timeout  = flush_timeout_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl (FLUSH_TO = 8). Inputs are driven and outputs
// are sampled 1ns after each rising edge.
module tb_trap_ctrl;
    localparam int AW = 64;
    localparam int DW = 64;

    logic          clk = 0;
    logic          rst = 0;
    logic          inst_valid = 0, inst_ecall = 0, inst_ebreak = 0, inst_mret = 0;
    logic [AW-1:0] inst_addr = '0, mtvec = '0, mepc = '0;
    logic          clint_mtip = 0, mstatus_mie = 0, mie_mtie = 0;
    logic          flush_ack = 0, redirect_ready = 0;
    logic          pipe_stall, flush_req, trap_en, ret_en, redirect_valid, flush_timeout;
    logic [DW-1:0] trap_cause;
    logic [AW-1:0] trap_epc, redirect_pc;

    int checks = 0;
    int errors = 0;

    trap_ctrl #(.ADDR_W(AW), .DATA_W(DW), .FLUSH_TO(8)) dut (
        .clk(clk), .rst(rst),
        .inst_valid(inst_valid), .inst_addr(inst_addr), .inst_ecall(inst_ecall),
        .inst_ebreak(inst_ebreak), .inst_mret(inst_mret),
        .clint_mtip(clint_mtip), .mstatus_mie(mstatus_mie), .mie_mtie(mie_mtie),
        .mtvec(mtvec), .mepc(mepc), .flush_ack(flush_ack), .redirect_ready(redirect_ready),
        .pipe_stall(pipe_stall), .flush_req(flush_req), .trap_en(trap_en), .ret_en(ret_en),
        .trap_cause(trap_cause), .trap_epc(trap_epc), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .flush_timeout(flush_timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inst();
        inst_valid = 0; inst_ecall = 0; inst_ebreak = 0; inst_mret = 0;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({pipe_stall, flush_req, trap_en, ret_en, redirect_valid, flush_timeout} !== 6'b0 ||
            trap_cause !== '0 || trap_epc !== '0 || redirect_pc !== '0) begin
            errors++;
            $display("FAIL reset_outputs ctl=%b cause=%h epc=%h pc=%h (want all 0)",
                     {pipe_stall, flush_req, trap_en, ret_en, redirect_valid, flush_timeout},
                     trap_cause, trap_epc, redirect_pc);
        end
        tick();
        rst = 1;
        tick();
    endtask

    task automatic test_ecall();
        mtvec = 64'h8000_0000; inst_addr = 64'h8000_0100; redirect_ready = 1;
        inst_valid = 1; inst_ecall = 1;
        tick();                              // sampled
        clr_inst();
        checks++;
        if (flush_req !== 1 || pipe_stall !== 1 || trap_en !== 0) begin
            errors++;
            $display("FAIL ecall_flush1 req=%b stall=%b trap=%b want 1 1 0", flush_req, pipe_stall, trap_en);
        end
        tick();
        checks++;
        if (flush_req !== 1) begin
            errors++; $display("FAIL ecall_flush2 req=%b want 1", flush_req);
        end
        flush_ack = 1;
        tick();
        flush_ack = 0;
        checks++;
        if (flush_req !== 0 || trap_en !== 1 || ret_en !== 0 ||
            trap_cause !== 64'd11 || trap_epc !== 64'h8000_0100) begin
            errors++;
            $display("FAIL ecall_commit req=%b trap=%b ret=%b cause=%h epc=%h want 0 1 0 b 80000100",
                     flush_req, trap_en, ret_en, trap_cause, trap_epc);
        end
        tick();
        checks++;
        if (trap_en !== 0 || redirect_valid !== 1 || redirect_pc !== 64'h8000_0000) begin
            errors++;
            $display("FAIL ecall_redirect trap=%b rv=%b pc=%h want 0 1 80000000", trap_en, redirect_valid, redirect_pc);
        end
        tick();
        checks++;
        if (redirect_valid !== 0 || pipe_stall !== 0) begin
            errors++; $display("FAIL ecall_idle rv=%b stall=%b want 0 0", redirect_valid, pipe_stall);
        end
    endtask

    task automatic test_irq_ebreak();
        // flush_ack already high while IDLE (ignored), so FLUSH lasts one cycle.
        mtvec = 64'h8000_0001; inst_addr = 64'h8000_0200; redirect_ready = 1; flush_ack = 1;
        clint_mtip = 1; mstatus_mie = 1; mie_mtie = 1;
        inst_valid = 1; inst_ebreak = 1;
        tick();
        clr_inst();
        clint_mtip = 0;                      // drops after sampling; event still completes
        checks++;
        if (flush_req !== 1 || trap_en !== 0) begin
            errors++; $display("FAIL irq_flush req=%b trap=%b want 1 0", flush_req, trap_en);
        end
        tick();
        flush_ack = 0;
        checks++;
        if (trap_en !== 1 || flush_req !== 0 || trap_cause !== 64'h8000_0000_0000_0007 ||
            trap_epc !== 64'h8000_0200) begin
            errors++;
            $display("FAIL irq_commit trap=%b req=%b cause=%h epc=%h want 1 0 8000000000000007 80000200",
                     trap_en, flush_req, trap_cause, trap_epc);
        end
        tick();
        checks++;
        if (redirect_valid !== 1 || redirect_pc !== 64'h8000_001C) begin
            errors++; $display("FAIL irq_vector rv=%b pc=%h want 1 8000001c", redirect_valid, redirect_pc);
        end
        tick();
        checks++;
        if (pipe_stall !== 0 || redirect_valid !== 0) begin
            errors++; $display("FAIL irq_idle stall=%b rv=%b want 0 0", pipe_stall, redirect_valid);
        end
    endtask

    task automatic test_mret_backpressure();
        mepc = 64'h8000_0204; redirect_ready = 0; flush_ack = 1;
        inst_addr = 64'h8000_0300; inst_valid = 1; inst_mret = 1;
        tick();
        clr_inst();
        tick();
        flush_ack = 0;
        checks++;
        if (ret_en !== 1 || trap_en !== 0 || trap_cause !== 64'h8000_0000_0000_0007 ||
            trap_epc !== 64'h8000_0200) begin
            errors++;
            $display("FAIL mret_commit ret=%b trap=%b cause=%h epc=%h want 1 0 8000000000000007 80000200",
                     ret_en, trap_en, trap_cause, trap_epc);
        end
        tick();
        mepc = 64'h1234;                     // target already latched
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (redirect_valid !== 1 || redirect_pc !== 64'h8000_0204 || ret_en !== 0) begin
                errors++;
                $display("FAIL mret_hold%0d rv=%b pc=%h ret=%b want 1 80000204 0", i, redirect_valid, redirect_pc, ret_en);
            end
            if (i == 3) redirect_ready = 1;
            tick();
        end
        checks++;
        if (redirect_valid !== 0 || pipe_stall !== 0) begin
            errors++; $display("FAIL mret_idle rv=%b stall=%b want 0 0", redirect_valid, pipe_stall);
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        mtvec = 64'h8000_0000; inst_addr = 64'h8000_0400; redirect_ready = 0; flush_ack = 0;
        inst_valid = 1; inst_ecall = 1;
        tick();
        clr_inst();
        while (flush_req === 1 && n < 20) begin
            n++;
            tick();
        end
        checks++;
        if (n != 8 || trap_en !== 1 || flush_timeout !== 1) begin
            errors++;
            $display("FAIL timeout_exit cycles=%0d trap=%b to=%b want 8 1 1", n, trap_en, flush_timeout);
        end
        tick();
        redirect_ready = 1;
        tick();
        tick();
        checks++;
        if (flush_timeout !== 1 || pipe_stall !== 0) begin
            errors++; $display("FAIL timeout_sticky to=%b stall=%b want 1 0", flush_timeout, pipe_stall);
        end
    endtask

    task automatic test_async_reset();
        int seen = 0;
        inst_addr = 64'h8000_0500; flush_ack = 0;
        inst_valid = 1; inst_ecall = 1;
        tick();
        clr_inst();
        tick();                              // mid FLUSH
        #2 rst = 0;
        #1;
        checks++;
        if ({pipe_stall, flush_req, trap_en, redirect_valid, flush_timeout} !== 5'b0 ||
            trap_cause !== '0 || trap_epc !== '0) begin
            errors++;
            $display("FAIL async_reset ctl=%b cause=%h epc=%h want 0",
                     {pipe_stall, flush_req, trap_en, redirect_valid, flush_timeout}, trap_cause, trap_epc);
        end
        flush_ack = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (trap_en !== 0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL reset_no_trap trap_en_cycles=%0d want 0", seen);
        end
        rst = 1;
        inst_addr = 64'h8000_0600; inst_valid = 1; inst_ecall = 1;
        tick();
        clr_inst();
        tick();
        flush_ack = 0;
        checks++;
        if (trap_en !== 1 || trap_cause !== 64'd11 || trap_epc !== 64'h8000_0600) begin
            errors++;
            $display("FAIL post_reset_ecall trap=%b cause=%h epc=%h want 1 b 80000600", trap_en, trap_cause, trap_epc);
        end
        tick();
        tick();
    endtask

    task automatic test_irq_masked();
        mtvec = 64'hFFFF_FFFF_FFFF_FFF1;     // vectored; base + 28 wraps past zero
        clint_mtip = 1; mstatus_mie = 0; mie_mtie = 1; redirect_ready = 1; flush_ack = 1;
        inst_addr = 64'h8000_0700; inst_valid = 1;
        tick();
        checks++;
        if (flush_req !== 0 || pipe_stall !== 0) begin
            errors++; $display("FAIL irq_masked req=%b stall=%b want 0 0", flush_req, pipe_stall);
        end
        mstatus_mie = 1;
        tick();
        clr_inst();
        checks++;
        if (flush_req !== 1) begin
            errors++; $display("FAIL irq_unmasked req=%b want 1", flush_req);
        end
        tick();
        flush_ack = 0;
        checks++;
        if (trap_en !== 1 || trap_cause !== 64'h8000_0000_0000_0007 || trap_epc !== 64'h8000_0700) begin
            errors++;
            $display("FAIL irq_late_commit trap=%b cause=%h epc=%h want 1 8000000000000007 80000700",
                     trap_en, trap_cause, trap_epc);
        end
        tick();
        checks++;
        if (redirect_valid !== 1 || redirect_pc !== 64'h0000_0000_0000_000C) begin
            errors++; $display("FAIL vector_wrap rv=%b pc=%h want 1 c", redirect_valid, redirect_pc);
        end
        clint_mtip = 0;
        tick();
    endtask

    initial begin
        test_reset();
        test_ecall();
        test_irq_ebreak();
        test_mret_backpressure();
        test_timeout();
        test_async_reset();
        test_irq_masked();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule
